execute: RTL and testbench
==========================

EXECUTE -- requirements
Module: execute

Interface
REQ-001 Parameter DATAW, default 32, SHALL set the operand/result width; it SHALL be a multiple of 4 and at least 32.
REQ-002 Parameter PCW, default 32, SHALL set the program-counter width; it SHALL be at least 11.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for the output stage registers.
REQ-005 rst  input  1  asynchronous active-high reset of the stage registers.
REQ-006 alu_op  input  1  operation select: 0 = add (a+b), 1 = increment (a+1).
REQ-007 branch_in  input  1  instruction is a conditional branch.
REQ-008 use_imm  input  1  select the shifted-immediate result instead of the ALU result.
REQ-009 shift_dist  input  2  byte-lane select for immediate placement.
REQ-010 a  input  DATAW  first operand, unsigned.
REQ-011 b  input  DATAW  second operand, unsigned.
REQ-012 imm  input  11  immediate field, unsigned, zero-extended wherever widened.
REQ-013 PC_in  input  PCW  current program counter.
REQ-014 en  input  1  stage-register load enable.
REQ-015 ex_out  output  DATAW  combinational execute result.
REQ-016 branch_out  output  1  combinational branch-taken flag.
REQ-017 PC_out  output  PCW  combinational branch target.
REQ-018 ex_out_q, branch_out_q, PC_out_q  output  DATAW/1/PCW  registered copies of the three results.

Function
REQ-019 ex_out, branch_out and PC_out SHALL be purely combinational from the inputs, with no clock dependence and zero-cycle latency.
REQ-020 When use_imm=1, ex_out SHALL be {zero-extended imm[7:0]} << (shift_dist*DATAW/4), truncated to DATAW bits; imm[10:8], a, b and alu_op SHALL be ignored. For DATAW=32 the shifts are 0, 8, 16 and 24.
REQ-021 When use_imm=0 and alu_op=0, ex_out SHALL be (a+b) mod 2^DATAW, with the carry discarded.
REQ-022 When use_imm=0 and alu_op=1, ex_out SHALL be (a+1) mod 2^DATAW; all-ones SHALL wrap to 0.
REQ-023 branch_out SHALL be branch_in AND (alu_op ? (a > b, unsigned) : (((a+b) mod 2^DATAW) != 0)).
REQ-024 branch_out SHALL be independent of use_imm and shift_dist.
REQ-025 With a == b and alu_op=1, branch_out SHALL be 0, because the comparison is strictly greater-than.
REQ-026 PC_out SHALL be (PC_in + zero-extended imm) mod 2^PCW, computed in every cycle regardless of branch_in, use_imm or alu_op.
REQ-027 On each rising clk edge with en=1 and rst=0, the _q outputs SHALL load the current combinational values. With en=0 they SHALL hold.
REQ-028 There SHALL be no X propagation for fully defined inputs.
REQ-029 No internal state other than the three _q registers SHALL exist.

Reset
REQ-030 While rst=1, ex_out_q, branch_out_q and PC_out_q SHALL be 0, asynchronously, independent of clk and en.
REQ-031 Combinational outputs SHALL be unaffected by rst.
REQ-032 After rst deasserts, the first rising edge with en=1 SHALL load the registers. Reset asserted mid-operation SHALL clear the registers immediately.

Verification
REQ-033 use_imm=0, alu_op=0, a=0xFFFFFFFF, b=1, branch_in=1 -> ex_out=0, branch_out=0 (wrapped sum is zero).
REQ-034 use_imm=0, alu_op=1, a=5, b=5, branch_in=1 -> ex_out=6, branch_out=0. Then a=6, b=5 -> branch_out=1. Then branch_in=0 -> branch_out=0.
REQ-035 use_imm=1, imm=0x7AB, shift_dist=0..3 -> ex_out=0x000000AB, 0x0000AB00, 0x00AB0000, 0xAB000000.
REQ-036 PC_in=0xFFFFFFFF, imm=0x7FF -> PC_out=0x000007FE (wrap, zero-extended immediate).
REQ-037 Registered path: rst=1 -> _q outputs = 0. Release rst, en=1, a=2, b=3, alu_op=0, use_imm=0 -> after one rising edge ex_out_q=5. Set en=0 and change a -> ex_out_q holds 5.
REQ-038 Randomized: 200 vectors with use_imm=0 and use_imm=1, random a, b, alu_op, branch_in, PC_in, imm and shift_dist -> all outputs match REQ-020 to REQ-026, checked 2 time units after each input change.

Source files
------------

// File: rtl/execute_if.sv
// Operand, control and result bundle for the execute stage.
// master drives the operands and controls; slave (the execute stage) drives the results.
interface execute_if #(
  parameter int DATAW = 32,
  parameter int PCW   = 32
);
  logic             alu_op;
  logic             branch_in;
  logic             use_imm;
  logic [1:0]       shift_dist;
  logic [DATAW-1:0] a;
  logic [DATAW-1:0] b;
  logic [10:0]      imm;
  logic [PCW-1:0]   PC_in;
  logic             en;
  logic [DATAW-1:0] ex_out;
  logic             branch_out;
  logic [PCW-1:0]   PC_out;
  logic [DATAW-1:0] ex_out_q;
  logic             branch_out_q;
  logic [PCW-1:0]   PC_out_q;

  modport master (
    output alu_op, branch_in, use_imm, shift_dist, a, b, imm, PC_in, en,
    input  ex_out, branch_out, PC_out, ex_out_q, branch_out_q, PC_out_q
  );

  modport slave (
    input  alu_op, branch_in, use_imm, shift_dist, a, b, imm, PC_in, en,
    output ex_out, branch_out, PC_out, ex_out_q, branch_out_q, PC_out_q
  );
endinterface

// File: rtl/execute.sv
// Execute stage: add/increment ALU, byte-lane immediate placement, branch decision
// and branch target, with combinational results plus an enabled register copy.
module execute #(
  parameter int DATAW = 32,
  parameter int PCW   = 32
) (
  input logic     clk,
  input logic     rst,
  execute_if.slave bus
);
  localparam int LANE = DATAW / 4;

  generate
    if ((DATAW % 4) != 0 || DATAW < 32) begin : g_bad_dataw
      $error("execute: DATAW must be a multiple of 4 and at least 32");
    end
    if (PCW < 11) begin : g_bad_pcw
      $error("execute: PCW must be at least 11");
    end
  endgenerate

  logic [DATAW-1:0] imm_ext;
  logic [DATAW-1:0] imm_shifted;
  logic [DATAW-1:0] sum;
  logic [DATAW-1:0] incr;
  logic [DATAW-1:0] ex_comb;
  logic             br_comb;
  logic [PCW-1:0]   pc_comb;

  always_comb begin
    imm_ext     = DATAW'(bus.imm[7:0]);
    imm_shifted = imm_ext;
    case (bus.shift_dist)
      2'd0: imm_shifted = imm_ext;
      2'd1: imm_shifted = imm_ext << LANE;
      2'd2: imm_shifted = imm_ext << (2 * LANE);
      2'd3: imm_shifted = imm_ext << (3 * LANE);
      default: imm_shifted = imm_ext;
    endcase

    sum  = bus.a + bus.b;
    incr = bus.a + DATAW'(1);

    if (bus.use_imm)
      ex_comb = imm_shifted;
    else if (bus.alu_op)
      ex_comb = incr;
    else
      ex_comb = sum;

    // Branch condition is taken from the operands, never from the selected result.
    br_comb = bus.branch_in & (bus.alu_op ? (bus.a > bus.b) : (sum != '0));
    pc_comb = bus.PC_in + PCW'(bus.imm);
  end

  assign bus.ex_out     = ex_comb;
  assign bus.branch_out = br_comb;
  assign bus.PC_out     = pc_comb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.ex_out_q     <= '0;
      bus.branch_out_q <= 1'b0;
      bus.PC_out_q     <= '0;
    end else if (bus.en) begin
      bus.ex_out_q     <= ex_comb;
      bus.branch_out_q <= br_comb;
      bus.PC_out_q     <= pc_comb;
    end
  end
endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: directed corner cases, registered path and
// randomized vectors against an arithmetic reference model.
module tb_execute;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  execute_if #(.DATAW(32), .PCW(32)) bus ();

  execute #(.DATAW(32), .PCW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic longint unsigned mdl_ex(input bit use_imm, input bit alu_op,
                                             input longint unsigned a, input longint unsigned b,
                                             input int unsigned imm, input int unsigned sd);
    longint unsigned m32 = 64'h1_0000_0000;
    if (use_imm) return ((imm % 256) * (64'd1 << (8 * sd))) % m32;
    if (alu_op)  return (a + 1) % m32;
    return (a + b) % m32;
  endfunction

  function automatic bit mdl_br(input bit bi, input bit alu_op,
                                input longint unsigned a, input longint unsigned b);
    if (!bi) return 1'b0;
    if (alu_op) return a > b;
    return ((a + b) % 64'h1_0000_0000) != 0;
  endfunction

  function automatic longint unsigned mdl_pc(input longint unsigned pc, input int unsigned imm);
    return (pc + imm) % 64'h1_0000_0000;
  endfunction

  task automatic drive(input bit use_imm, input bit alu_op, input bit bi,
                       input logic [31:0] a, input logic [31:0] b, input logic [10:0] imm,
                       input logic [1:0] sd, input logic [31:0] pc);
    bus.use_imm    = use_imm;
    bus.alu_op     = alu_op;
    bus.branch_in  = bi;
    bus.a          = a;
    bus.b          = b;
    bus.imm        = imm;
    bus.shift_dist = sd;
    bus.PC_in      = pc;
  endtask

  task automatic test_reset;
    bus.en = 1'b1;
    drive(0, 0, 1, 32'd7, 32'd9, 11'h123, 2'd1, 32'h100);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.ex_out_q !== 32'd0 || bus.branch_out_q !== 1'b0 || bus.PC_out_q !== 32'd0) begin
      n_err++;
      $display("FAIL reset_q: ex_q=%h br_q=%b pc_q=%h required 0/0/0",
               bus.ex_out_q, bus.branch_out_q, bus.PC_out_q);
    end
    n_cmp++;
    if (bus.ex_out !== 32'd16 || bus.PC_out !== 32'h223) begin
      n_err++;
      $display("FAIL reset_comb: ex=%h pc=%h required 00000010/00000223", bus.ex_out, bus.PC_out);
    end
  endtask

  task automatic test_add_wrap;
    drive(0, 0, 1, 32'hFFFF_FFFF, 32'd1, 11'd0, 2'd0, 32'd0);
    #2;
    n_cmp++;
    if (bus.ex_out !== 32'd0 || bus.branch_out !== 1'b0) begin
      n_err++;
      $display("FAIL add_wrap: ex=%h br=%b required 00000000/0", bus.ex_out, bus.branch_out);
    end
  endtask

  task automatic test_incr_branch;
    drive(0, 1, 1, 32'd5, 32'd5, 11'd0, 2'd0, 32'd0);
    #2;
    n_cmp++;
    if (bus.ex_out !== 32'd6 || bus.branch_out !== 1'b0) begin
      n_err++;
      $display("FAIL incr_equal: ex=%h br=%b required 00000006/0", bus.ex_out, bus.branch_out);
    end
    bus.a = 32'd6;
    #2;
    n_cmp++;
    if (bus.branch_out !== 1'b1) begin
      n_err++;
      $display("FAIL incr_greater: br=%b required 1", bus.branch_out);
    end
    bus.branch_in = 1'b0;
    #2;
    n_cmp++;
    if (bus.branch_out !== 1'b0) begin
      n_err++;
      $display("FAIL branch_in_low: br=%b required 0", bus.branch_out);
    end
    drive(0, 1, 1, 32'hFFFF_FFFF, 32'd0, 11'd0, 2'd0, 32'd0);
    #2;
    n_cmp++;
    if (bus.ex_out !== 32'd0 || bus.branch_out !== 1'b1) begin
      n_err++;
      $display("FAIL incr_wrap: ex=%h br=%b required 00000000/1", bus.ex_out, bus.branch_out);
    end
  endtask

  task automatic test_imm_shift;
    logic [31:0] exp_tab [4];
    exp_tab[0] = 32'h0000_00AB;
    exp_tab[1] = 32'h0000_AB00;
    exp_tab[2] = 32'h00AB_0000;
    exp_tab[3] = 32'hAB00_0000;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, 32'h1234_5678, 32'h9ABC_DEF0, 11'h7AB, 2'(i), 32'd0);
      #2;
      n_cmp++;
      if (bus.ex_out !== exp_tab[i]) begin
        n_err++;
        $display("FAIL imm_shift%0d: ex=%h required %h", i, bus.ex_out, exp_tab[i]);
      end
    end
  endtask

  task automatic test_pc_wrap;
    drive(0, 0, 0, 32'd0, 32'd0, 11'h7FF, 2'd0, 32'hFFFF_FFFF);
    #2;
    n_cmp++;
    if (bus.PC_out !== 32'h0000_07FE) begin
      n_err++;
      $display("FAIL pc_wrap: pc=%h required 000007FE", bus.PC_out);
    end
  endtask

  task automatic test_registered;
    @(negedge clk);
    rst = 1'b1;
    bus.en = 1'b1;
    drive(0, 0, 1, 32'd2, 32'd3, 11'h010, 2'd0, 32'h40);
    #1;
    n_cmp++;
    if (bus.ex_out_q !== 32'd0) begin
      n_err++;
      $display("FAIL reg_in_reset: ex_q=%h required 00000000", bus.ex_out_q);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.ex_out_q !== 32'd5 || bus.branch_out_q !== 1'b1 || bus.PC_out_q !== 32'h50) begin
      n_err++;
      $display("FAIL reg_load: ex_q=%h br_q=%b pc_q=%h required 00000005/1/00000050",
               bus.ex_out_q, bus.branch_out_q, bus.PC_out_q);
    end
    @(negedge clk);
    bus.en = 1'b0;
    bus.a  = 32'd100;
    bus.PC_in = 32'h999;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.ex_out_q !== 32'd5 || bus.PC_out_q !== 32'h50) begin
      n_err++;
      $display("FAIL reg_hold: ex_q=%h pc_q=%h required 00000005/00000050",
               bus.ex_out_q, bus.PC_out_q);
    end
    @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.ex_out_q !== 32'd103 || bus.PC_out_q !== 32'h9A9) begin
      n_err++;
      $display("FAIL reg_reload: ex_q=%h pc_q=%h required 00000067/000009A9",
               bus.ex_out_q, bus.PC_out_q);
    end
  endtask

  task automatic test_async_reset;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.ex_out_q !== 32'd0 || bus.branch_out_q !== 1'b0 || bus.PC_out_q !== 32'd0) begin
      n_err++;
      $display("FAIL async_reset: ex_q=%h br_q=%b pc_q=%h required 0/0/0",
               bus.ex_out_q, bus.branch_out_q, bus.PC_out_q);
    end
    n_cmp++;
    if (bus.ex_out !== 32'd103) begin
      n_err++;
      $display("FAIL comb_in_reset: ex=%h required 00000067", bus.ex_out);
    end
    #5;
    rst = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] ra, rb, rpc;
    logic [10:0] rimm;
    logic [1:0]  rsd;
    bit          ru, rop, rbi;
    longint unsigned e_ex, e_pc;
    bit e_br;
    bus.en = 1'b0;
    for (int i = 0; i < 200; i++) begin
      ru   = 1'(i % 2);
      rop  = 1'($urandom_range(0, 1));
      rbi  = 1'($urandom_range(0, 1));
      ra   = $urandom;
      rb   = (i % 7 == 0) ? ra : $urandom;
      if (i % 11 == 0) rb = -ra;
      rimm = 11'($urandom);
      rsd  = 2'($urandom);
      rpc  = $urandom;
      drive(ru, rop, rbi, ra, rb, rimm, rsd, rpc);
      #2;
      e_ex = mdl_ex(ru, rop, ra, rb, rimm, rsd);
      e_br = mdl_br(rbi, rop, ra, rb);
      e_pc = mdl_pc(rpc, rimm);
      n_cmp++;
      if (bus.ex_out !== e_ex[31:0] || bus.branch_out !== e_br || bus.PC_out !== e_pc[31:0]) begin
        n_err++;
        $display("FAIL rand%0d: ex=%h br=%b pc=%h required %h/%b/%h", i,
                 bus.ex_out, bus.branch_out, bus.PC_out, e_ex[31:0], e_br, e_pc[31:0]);
      end
      #1;
    end
  endtask

  initial begin
    test_reset();
    rst = 1'b0;
    test_add_wrap();
    test_incr_branch();
    test_imm_shift();
    test_pc_wrap();
    test_registered();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
